// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: request/response bus between the MEM stage and data memory
interface data_memory_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    mem_data_write_en;
  logic [ADDR_WIDTH-1:0]   mem_data_address;
  logic [DATA_WIDTH-1:0]   mem_data_write;
  logic [DATA_WIDTH/8-1:0] mem_byte_en;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [DATA_WIDTH-1:0]   mem_data_read;
  logic                    resp_error;
  modport master (
    output req_valid, mem_data_write_en, mem_data_address, mem_data_write, mem_byte_en, resp_ready,
    input  req_ready, resp_valid, mem_data_read, resp_error
  );
  modport slave (
    input  req_valid, mem_data_write_en, mem_data_address, mem_data_write, mem_byte_en, resp_ready,
    output req_ready, resp_valid, mem_data_read, resp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-outstanding data memory with byte-lane writes and programmable wait states
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input logic clk,
  input logic rst,
  data_memory_responder_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NB-1:0]         be_q, be_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic                  accept, fire, done, in_idle, a_we, a_err;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic [NB-1:0]         a_be;
  logic [IW-1:0]         idx;
  // With zero wait states the memory acts on the accept edge, so the live request is used instead of the latch
  always_comb begin
    in_idle      = state_q == S_IDLE;
    accept       = in_idle && bus.req_valid;
    done         = state_q == S_RESP && bus.resp_ready;
    a_addr       = in_idle ? bus.mem_data_address : addr_q;
    a_we         = in_idle ? bus.mem_data_write_en : we_q;
    a_wdata      = in_idle ? bus.mem_data_write : wdata_q;
    a_be         = in_idle ? bus.mem_byte_en : be_q;
    a_err        = a_addr[1:0] != 2'b00 || {2'b00, a_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH_WORDS);
    idx          = a_addr[IW+1:2];
    fire         = (accept && WAIT_STATES == 0) || (state_q == S_WAIT && cnt_q == 4'd0);
    state_d      = fire ? S_RESP : accept ? S_WAIT : done ? S_IDLE : state_q;
    cnt_d        = accept ? 4'(WAIT_STATES - 1) : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    we_d         = accept ? bus.mem_data_write_en : we_q;
    addr_d       = accept ? bus.mem_data_address : addr_q;
    wdata_d      = accept ? bus.mem_data_write : wdata_q;
    be_d         = accept ? bus.mem_byte_en : be_q;
    rdata_d      = fire ? ((a_err || a_we) ? '0 : mem[idx]) : done ? '0 : rdata_q;
    err_d        = fire ? a_err : done ? 1'b0 : err_q;
    req_ready_d  = state_d == S_IDLE;
    resp_valid_d = state_d == S_RESP;
  end
  // Control state and registered bus outputs; reset drops any in-flight request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end
  // Byte-lane store into storage, which reset leaves untouched
  always_ff @(posedge clk) begin
    if (!rst && fire && a_we && !a_err)
      for (int i = 0; i < NB; i++)
        if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
  end
  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.mem_data_read = rdata_q;
  assign bus.resp_error    = err_q;
endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder (memory) side of the data-memory interface driven by the pipeline MEM stage.
- Accepts one load or store request at a time and holds its word-addressed storage array.
- Applies byte-lane writes and returns read data after a programmable number of wait states, using a valid/ready handshake.
- Flags misaligned and out-of-range accesses so the core can stall or trap.

Parameters:
- ADDR_WIDTH, 12, byte-address width; matches PROGRAM_ADDRESS_WIDTH.
- DATA_WIDTH, 32, data word width; matches INSTRUCTION_WIDTH. Must be a multiple of 8.
- DEPTH_WORDS, 256, number of storage words. Must be ≤ 2^(ADDR_WIDTH-2).
- WAIT_STATES, 1, extra cycles between acceptance and response (0..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- mem_data_write_en  input  1  1 = store, 0 = load.
- mem_data_address  input  ADDR_WIDTH  byte address.
- mem_data_write  input  DATA_WIDTH  store data.
- mem_byte_en  input  DATA_WIDTH/8  store byte strobes; bit i covers bits [8i+7:8i]. Ignored for loads.
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- mem_data_read  output  DATA_WIDTH  load data; 0 for stores and errors.
- resp_error  output  1  access was misaligned or out of range.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - FSM goes to IDLE; wait counter = 0.
  - req_ready=1, resp_valid=0, mem_data_read=0, resp_error=0.
  - Storage contents are not cleared.
  - rst wins over any simultaneous handshake; an in-flight request is dropped with no write performed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch address, write enable, write data and byte strobes.
  - Compute error = (address[1:0] != 0) || (address >> 2 >= DEPTH_WORDS).
  - If WAIT_STATES=0 go to RESP; otherwise load counter = WAIT_STATES-1 and go to WAIT.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 0, go to RESP on the next edge.
- Memory action on the WAIT→RESP (or IDLE→RESP) transition edge:
  - Store with no error: for each set strobe bit, write that byte of the word at index address[ADDR_WIDTH-1:2]. Bytes with clear strobes are unchanged.
  - Load with no error: register the word at that index into mem_data_read.
  - Error, or store: mem_data_read=0 and storage is untouched.
  - resp_error is registered with the same timing.
- RESP:
  - resp_valid=1; mem_data_read and resp_error stay stable while resp_ready=0.
  - On resp_ready=1, go to IDLE; resp_valid=0 and mem_data_read=0 on the next cycle.
  - req_ready=0 in RESP, so there is no back-to-back acceptance. Minimum request spacing is WAIT_STATES+2 cycles.
- Latency: from the acceptance edge to resp_valid high is WAIT_STATES+1 cycles.
- Read-after-write: a load issued after a store's response completes returns the newly written data. Only one transaction is ever outstanding, so there is no hazard.
- Request inputs outside the accept cycle are ignored; they need not be held stable after acceptance.
- mem_byte_en = 0 on a store: the store completes with a normal response and storage is unchanged.

Test Plan:
- WAIT_STATES=1. Store 0xDEADBEEF to 0x010 with byte_en=1111, then load 0x010.
  - Store: resp_valid 2 cycles after acceptance, resp_error=0.
  - Load: returns 0xDEADBEEF, 2 cycles after acceptance.
- Partial store: store 0x000000AA to 0x010 with byte_en=0001, then load 0x010 -> returns 0xDEADBEAA.
- Misaligned load of 0x013, then load 0x010.
  - Load of 0x013 -> resp_error=1, mem_data_read=0.
  - Load of 0x010 -> still returns 0xDEADBEAA.
- Out of range: store to 0x400 (word 256, DEPTH_WORDS=256) -> resp_error=1. A following load of 0x000 returns its prior value, unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles during a load response.
  - resp_valid and data stay stable; req_ready=0 throughout.
  - A req_valid asserted in that window is not accepted until the cycle after the resp_ready handshake.
- Reset mid-operation: assert rst in the WAIT cycle of a store of 0x12345678 to 0x020.
  - Next cycle: req_ready=1, resp_valid=0, no response is ever produced.
  - A subsequent load of 0x020 returns the pre-store value.
  - Rerun with WAIT_STATES=0: resp_valid 1 cycle after acceptance.
